// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master among N_REQ requesters.
// Owner is held for a whole transfer; start and busy-stuck timeouts complete it with err.
module spi_arbiter #(
   parameter int N_REQ    = 4,
   parameter int START_TO = 16,
   parameter int XFER_TO  = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [8*N_REQ-1:0]       wdata,
   output logic [N_REQ-1:0]         ack,
   output logic [7:0]               rdata,
   output logic                     err,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] dev_sel,
   output logic                     m_start,
   output logic [7:0]               m_data_in,
   input  logic [7:0]               m_data_out,
   input  logic                     m_busy
);

   localparam int          SEL_W  = $clog2(N_REQ);
   localparam int          TO_MAX = (START_TO > XFER_TO) ? START_TO : XFER_TO;
   localparam int          CNT_W  = $clog2(TO_MAX + 1);
   localparam int unsigned NR     = N_REQ;

   typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, DONE} state_t;

   state_t           state;
   logic [SEL_W-1:0] last_ptr;
   logic [SEL_W-1:0] win_idx;
   logic             win_found;
   logic [CNT_W-1:0] cnt;
   int unsigned      cand;
   logic [SEL_W-1:0] cand_sel;

   // First requesting index after last_ptr, wrapping N_REQ-1 -> 0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_sel  = '0;
      for (int unsigned i = 1; i <= NR; i++) begin
         cand     = (32'(last_ptr) + i) % NR;
         cand_sel = cand[SEL_W-1:0];
         if (!win_found && req[cand_sel]) begin
            win_found = 1'b1;
            win_idx   = cand_sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         dev_sel   <= '0;
         m_start   <= 1'b0;
         m_data_in <= '0;
         ack       <= '0;
         err       <= 1'b0;
         rdata     <= '0;
         cnt       <= '0;
         last_ptr  <= SEL_W'(N_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant     <= N_REQ'(1) << win_idx;
                  dev_sel   <= win_idx;
                  m_data_in <= wdata[{win_idx, 3'b000} +: 8];
                  m_start   <= 1'b1;
                  cnt       <= '0;
                  state     <= START;
               end
            end
            START: begin
               m_start <= 1'b0;
               cnt     <= '0;
               state   <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (m_busy) begin
                  cnt   <= '0;
                  state <= WAIT_DONE;
               end else if (cnt == CNT_W'(START_TO - 1)) begin
                  err   <= 1'b1;
                  rdata <= '0;
                  ack   <= grant;
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               if (!m_busy) begin
                  err   <= 1'b0;
                  rdata <= m_data_out;
                  ack   <= grant;
                  cnt   <= '0;
                  state <= DONE;
               end else if (cnt == CNT_W'(XFER_TO - 1)) begin
                  err   <= 1'b1;
                  rdata <= '0;
                  ack   <= grant;
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               // ack/err are registered on DONE entry, so they span exactly this cycle.
               ack      <= '0;
               err      <= 1'b0;
               grant    <= '0;
               last_ptr <= dev_sel;
               cnt      <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: vector table of single transfers plus
// hand-written reset, contention and fairness sequences against a behavioural spi_master.
module tb_spi_arbiter;

   localparam int START_TO = 16;
   localparam int XFER_TO  = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] wdata;
   logic [3:0]  ack;
   logic [7:0]  rdata;
   logic        err;
   logic [3:0]  grant;
   logic [1:0]  dev_sel;
   logic        m_start;
   logic [7:0]  m_data_in;
   logic [7:0]  m_data_out;
   logic        m_busy;

   int n_chk  = 0;
   int n_fail = 0;

   // slave_mode: 0 = never busy, 1 = busy for busy_len cycles, 2 = busy until ack
   int         slave_mode = 0;
   int         busy_len   = 1;
   logic [7:0] rx_byte    = 8'h00;

   spi_arbiter #(.N_REQ(4), .START_TO(START_TO), .XFER_TO(XFER_TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .ack(ack),
      .rdata(rdata), .err(err), .grant(grant), .dev_sel(dev_sel),
      .m_start(m_start), .m_data_in(m_data_in), .m_data_out(m_data_out),
      .m_busy(m_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_busy     = 1'b0;
      m_data_out = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && m_start === 1'b1) begin
            case (slave_mode)
               1: begin
                  @(posedge clk); #1 m_busy = 1'b1;
                  repeat (busy_len) @(posedge clk);
                  #1 m_busy = 1'b0;
                  m_data_out = rx_byte;
               end
               2: begin
                  @(posedge clk); #1 m_busy = 1'b1;
                  m_data_out = 8'hEE;
                  do @(negedge clk); while (ack == 4'b0 && rst_n === 1'b1);
                  m_busy = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Called at a negedge with req already driven. drop: 0 keep, 1 own bit, 2 all.
   task automatic xfer(input string nm, input int exp_dev, input logic exp_err,
                       input logic [7:0] exp_rd, input int exp_lat, input int drop);
      int n;
      int lat;
      int extra_starts;
      logic [7:0] exp_mdi;
      logic [3:0] exp_oh;
      exp_oh  = 4'b0001 << exp_dev;
      exp_mdi = wdata[8*exp_dev +: 8];
      n = 0;
      while (m_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk({nm, "_start_seen"}, 32'(m_start), 1);
      chk({nm, "_grant"}, 32'(grant), 32'(exp_oh));
      chk({nm, "_dev_sel"}, 32'(dev_sel), exp_dev);
      chk({nm, "_m_data_in"}, 32'(m_data_in), 32'(exp_mdi));
      lat = 0;
      extra_starts = 0;
      while (ack == 4'b0 && lat < XFER_TO + 50) begin
         @(negedge clk);
         lat++;
         if (m_start === 1'b1) extra_starts++;
      end
      chk({nm, "_ack"}, 32'(ack), 32'(exp_oh));
      chk({nm, "_err"}, 32'(err), 32'(exp_err));
      chk({nm, "_rdata"}, 32'(rdata), 32'(exp_rd));
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_single_start"}, extra_starts, 0);
      if (drop == 1) req = req & ~ack;
      else if (drop == 2) req = 4'b0;
      @(negedge clk);
      chk({nm, "_ack_cleared"}, 32'(ack), 0);
      chk({nm, "_err_cleared"}, 32'(err), 0);
      chk({nm, "_grant_idle"}, 32'(grant), 0);
      chk({nm, "_rdata_held"}, 32'(rdata), 32'(exp_rd));
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [31:0] wdata;
      int          mode;
      int          blen;
      logic [7:0]  rx;
      int          exp_dev;
      logic        exp_err;
      logic [7:0]  exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [3:0] seen;
      int fair_seq[6];

      vecs[0] = '{4'b0100, 32'h00A5_0000, 1, 80, 8'h3C, 2, 1'b0, 8'h3C, 82};
      vecs[1] = '{4'b0011, 32'h0000_2211, 1, 5,  8'h5A, 0, 1'b0, 8'h5A, 7};
      vecs[2] = '{4'b0011, 32'h0000_2211, 1, 3,  8'h77, 1, 1'b0, 8'h77, 5};
      vecs[3] = '{4'b1001, 32'hF000_000F, 0, 0,  8'h99, 3, 1'b1, 8'h00, START_TO + 1};
      vecs[4] = '{4'b1001, 32'hF000_000F, 1, 1,  8'hC3, 0, 1'b0, 8'hC3, 3};
      vecs[5] = '{4'b1111, 32'h4433_2211, 2, 0,  8'h00, 1, 1'b1, 8'h00, XFER_TO + 2};
      fair_seq = '{0, 1, 3, 0, 1, 3};

      rst_n = 1'b0;
      req   = 4'b0;
      wdata = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset_grant", 32'(grant), 0);
      chk("reset_dev_sel", 32'(dev_sel), 0);
      chk("reset_m_start", 32'(m_start), 0);
      chk("reset_m_data_in", 32'(m_data_in), 0);
      chk("reset_ack", 32'(ack), 0);
      chk("reset_err", 32'(err), 0);
      chk("reset_rdata", 32'(rdata), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         slave_mode = vecs[i].mode;
         busy_len   = vecs[i].blen;
         rx_byte    = vecs[i].rx;
         wdata      = vecs[i].wdata;
         req        = vecs[i].req;
         xfer($sformatf("vec%0d", i), vecs[i].exp_dev, vecs[i].exp_err,
              vecs[i].exp_rd, vecs[i].exp_lat, 2);
         repeat (2) @(negedge clk);
      end

      // Reset during WAIT_DONE: outputs clear immediately, no ack, requester 0 wins next.
      slave_mode = 2;
      wdata      = 32'h005B_0000;
      req        = 4'b0100;
      begin
         int n;
         n = 0;
         while (m_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      end
      chk("rst_mid_granted", 32'(grant), 32'h4);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_grant", 32'(grant), 0);
      chk("rst_mid_dev_sel", 32'(dev_sel), 0);
      chk("rst_mid_m_data_in", 32'(m_data_in), 0);
      chk("rst_mid_ack", 32'(ack), 0);
      chk("rst_mid_err", 32'(err), 0);
      req = 4'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 4'b0;
      repeat (10) begin
         @(negedge clk);
         seen = seen | ack;
      end
      chk("rst_mid_no_ack", 32'(seen), 0);

      // Contention: all request, each drops on its own ack, one IDLE cycle between.
      slave_mode = 1;
      busy_len   = 2;
      rx_byte    = 8'h81;
      wdata      = 32'hD4C3_B2A1;
      req        = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         xfer($sformatf("cont%0d", k), k, 1'b0, 8'h81, 4, 1);
         if (k < 3) begin
            @(negedge clk);
            chk($sformatf("cont%0d_next_start", k), 32'(m_start), 1);
         end
      end
      chk("cont_req_drained", 32'(req), 0);
      repeat (3) @(negedge clk);

      // Fairness: req=1011 held continuously for six transfers.
      rx_byte = 8'h42;
      req     = 4'b1011;
      for (int k = 0; k < 6; k++) begin
         xfer($sformatf("fair%0d", k), fair_seq[k], 1'b0, 8'h42, 4, 0);
      end
      req = 4'b0;
      repeat (12) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters (2..8).
REQ-002 Parameter: START_TO, 16, max cycles from m_start to m_busy rising.
REQ-003 Parameter: XFER_TO, 1024, max cycles m_busy may stay high.
REQ-004 Port: clk  input  1  system clock, all logic on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: req  input  N_REQ  per-requester transfer request, level, held until ack.
REQ-007 Port: wdata  input  8*N_REQ  per-requester TX byte, slice k = bits [8k+7:8k], stable while req[k]=1.
REQ-008 Port: ack  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-009 Port: rdata  output  8  received byte, valid when any ack bit = 1.
REQ-010 Port: err  output  1  timeout flag, valid with ack.
REQ-011 Port: grant  output  N_REQ  one-hot owner of the SPI master, 0 when idle.
REQ-012 Port: dev_sel  output  clog2(N_REQ)  index of owner, drives the external slave-select mux.
REQ-013 Port: m_start  output  1  start pulse to spi_master.
REQ-014 Port: m_data_in  output  8  TX byte to spi_master.
REQ-015 Port: m_data_out  input  8  RX byte from spi_master.
REQ-016 Port: m_busy  input  1  spi_master busy.

Function
REQ-017 The FSM SHALL have states IDLE, START, WAIT_BUSY, WAIT_DONE, DONE.
REQ-018 IDLE: if req != 0, the FSM SHALL grant round-robin, searching from last_ptr+1 upward with wrap at N_REQ-1 -> 0, and SHALL go to START; otherwise it SHALL stay in IDLE.
REQ-019 On the grant edge, grant, dev_sel, and m_data_in (= wdata slice of the winner) SHALL be registered and then held constant until the DONE -> IDLE transition.
REQ-020 START SHALL last exactly 1 cycle, with m_start=1 only in this state, and SHALL then go to WAIT_BUSY.
REQ-021 WAIT_BUSY: m_busy=1 SHALL go to WAIT_DONE; START_TO cycles without m_busy SHALL set err_r=1 and go to DONE.
REQ-022 WAIT_DONE: m_busy=0 SHALL capture m_data_out into rdata, set err_r=0, and go to DONE; XFER_TO cycles with m_busy still high SHALL set err_r=1, rdata=8'h00, and go to DONE.
REQ-023 The timeout counter SHALL clear on every state entry and SHALL be wide enough for max(START_TO, XFER_TO).
REQ-024 DONE SHALL last exactly 1 cycle with ack = grant and err = err_r; it SHALL then set last_ptr = dev_sel, clear grant, and go to IDLE.
REQ-025 ack and err SHALL be 0 in every state other than DONE; rdata SHALL hold its last value.
REQ-026 The latency SHALL be a minimum of 1 IDLE cycle + 1 START + WAIT_BUSY + WAIT_DONE + 1 DONE cycle, and the arbiter SHALL add 3 cycles of overhead on top of the SPI transfer.
REQ-027 Requests arriving or dropping outside IDLE SHALL be ignored until the next IDLE; arbitration SHALL not be preemptive.
REQ-028 A requester dropping req before its ack SHALL not abort the transfer; its ack SHALL still be issued.
REQ-029 Back-to-back transfers: IDLE SHALL always last at least 1 cycle after DONE, so a requester clearing req on the ack edge is not re-granted.
REQ-030 With all req bits set continuously, grants SHALL rotate 0,1,2,...,N_REQ-1,0, giving no starvation.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force state=IDLE, grant=0, dev_sel=0, m_start=0, m_data_in=8'h00, ack=0, err=0, rdata=8'h00, counter=0, and last_ptr=N_REQ-1 (requester 0 wins first).
REQ-032 A reset mid-transfer SHALL abandon the transfer with no ack; the spi_master shares the same reset.

Verification
REQ-033 Single request: req=4'b0100, wdata[23:16]=8'hA5, model busy high for 80 cycles and returning 8'h3C -> one m_start pulse, m_data_in=8'hA5, dev_sel=2, ack=4'b0100 with rdata=8'h3C and err=0.
REQ-034 Contention: req=4'b1111 held, each requester dropping on its own ack -> ack order 0,1,2,3, each ack exactly 1 cycle, with 1 IDLE cycle between transfers.
REQ-035 Fairness: req=4'b1011 continuous for 6 transfers -> grant sequence 0,1,3,0,1,3.
REQ-036 Start timeout: m_busy tied 0 -> ack with err=1 and rdata=8'h00 exactly START_TO cycles after WAIT_BUSY entry, then return to IDLE.
REQ-037 Busy stuck: m_busy held 1 -> err=1 after XFER_TO cycles in WAIT_DONE.
REQ-038 Reset mid-operation: rst_n=0 during WAIT_DONE -> all outputs at reset values in the same cycle, no ack, and the next grant goes to requester 0.
